t07_fpu_sequencer: RTL

Issue-side controller for the team's FPU. It accepts floating-point requests from the CPU control path over a valid/ready handshake and registers the operands onto the FPU inputs. It then waits out the FPU's `busy` for multi-cycle ops (FDIV) and returns the captured result over a valid/ready response channel. It also owns the `fcsr` register (`frm` and sticky `fflags`) that feeds the FPU's `fcsr_in`.

---
 rtl/t07_fpu_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/t07_fpu_sequencer.sv
// Issue-side FPU controller: accepts one request at a time, drives the FPU inputs,
// waits out multi-cycle busy (with timeout), returns the result and owns fcsr.
module t07_fpu_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [4:0]  IDLE_OP = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_c,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_rd,
  output logic        rsp_timeout,
  output logic [4:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  output logic [31:0] fpu_fcsr,
  input  logic [31:0] fpu_result,
  input  logic        fpu_busy,
  input  logic        fpu_overflow,
  input  logic        csr_we,
  input  logic [7:0]  csr_wdata
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [4:0]    rsp_rd_q, rsp_rd_d;
  logic [4:0]    fpu_op_q, fpu_op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    frm_q, frm_d;
  logic [4:0]    fflags_q, fflags_d;
  logic [4:0]    flags_set;
  logic          capture;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    rsp_rd_d      = rsp_rd_q;
    fpu_op_d      = fpu_op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    flags_set     = '0;
    capture       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          a_d      = req_a;
          b_d      = req_b;
          c_d      = req_c;
          rsp_rd_d = req_rd;
          // Divide-by-zero is answered locally; the FPU never sees the op.
          if (req_op == 5'd7 && req_b == '0) begin
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
            rsp_result_d  = '0;
            rsp_timeout_d = 1'b0;
            flags_set[3]  = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            fpu_op_d = req_op;
          end
        end
      end
      S_ISSUE: begin
        if (!fpu_busy) begin
          capture = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A busy drop on the final count still counts as a normal completion.
        if (!fpu_busy) begin
          capture = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_RESP;
          fpu_op_d      = IDLE_OP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          flags_set[4]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      state_d       = S_RESP;
      fpu_op_d      = IDLE_OP;
      rsp_valid_d   = 1'b1;
      rsp_result_d  = fpu_result;
      rsp_timeout_d = 1'b0;
      if ((op_q == 5'd21 || op_q == 5'd22) && fpu_overflow) flags_set[2] = 1'b1;
    end

    // Flags raised on a CSR-write edge are merged into the written value.
    fflags_d = (csr_we ? csr_wdata[4:0] : fflags_q) | flags_set;
    frm_d    = csr_we ? csr_wdata[7:5] : frm_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      rsp_rd_q      <= '0;
      fpu_op_q      <= IDLE_OP;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
      frm_q         <= '0;
      fflags_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      rsp_rd_q      <= rsp_rd_d;
      fpu_op_q      <= fpu_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
      frm_q         <= frm_d;
      fflags_q      <= fflags_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_timeout = rsp_timeout_q;
  assign fpu_op      = fpu_op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_c       = c_q;
  assign fpu_fcsr    = {24'b0, frm_q, fflags_q};

endmodule
